// File: rtl/vend_pkg.sv
// Shared encodings for the vending sequencer: external state codes, internal FSM states, default sizing.
// Pure definitions; no logic, no latency, no flow control.
package vend_pkg;

  localparam int unsigned NUM_ITEMS_DEF  = 8;
  localparam int unsigned CNT_W_DEF      = 4;
  localparam int unsigned MAX_STOCK_DEF  = 15;
  localparam int unsigned INIT_STOCK_DEF = 5;
  localparam int unsigned TIMEOUT_DEF    = 1000;
  localparam int unsigned IDX_W          = 4;

  localparam logic [1:0] ST_SELECT   = 2'b00;
  localparam logic [1:0] ST_PAY      = 2'b01;
  localparam logic [1:0] ST_DISPENSE = 2'b10;
  localparam logic [1:0] ST_SERVICE  = 2'b11;

  typedef enum logic [2:0] {
    S_SELECT,
    S_PAY,
    S_DSP_ACK,
    S_DSP_REL,
    S_CXL_REQ,
    S_CXL_REL,
    S_SERVICE
  } fsm_e;

  // Cancel and dispense handshake sub-states report as their parent phase.
  function automatic logic [1:0] state_code(input fsm_e s);
    case (s)
      S_PAY, S_CXL_REQ, S_CXL_REL: state_code = ST_PAY;
      S_DSP_ACK, S_DSP_REL:        state_code = ST_DISPENSE;
      S_SERVICE:                   state_code = ST_SERVICE;
      default:                     state_code = ST_SELECT;
    endcase
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-item stock counters: saturating add, no-underflow decrement; reads are combinational, updates land next cycle.
// No backpressure: update strobes are single-cycle commands and always accepted.
module vend_inventory
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = NUM_ITEMS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MAX_STOCK  = MAX_STOCK_DEF,
  parameter int unsigned INIT_STOCK = INIT_STOCK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_en,
  input  logic [IDX_W-1:0] dec_idx,
  input  logic             add_en,
  input  logic [IDX_W-1:0] add_idx,
  input  logic [CNT_W-1:0] add_qty,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IDX_W-1:0] chk_idx,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam logic [CNT_W:0] SAT = (CNT_W + 1)'(MAX_STOCK);

  logic [CNT_W-1:0] cnt_q [NUM_ITEMS];
  logic [CNT_W-1:0] cnt_d [NUM_ITEMS];
  logic [CNT_W:0]   sum;

  always_comb begin
    rd_cnt  = '0;
    chk_cnt = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rd_idx == IDX_W'(i))  rd_cnt  = cnt_q[i];
      if (chk_idx == IDX_W'(i)) chk_cnt = cnt_q[i];
    end
  end

  // One extra bit on the sum so the clamp sees the true total before truncation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      cnt_d[i] = cnt_q[i];
      sum      = {1'b0, cnt_q[i]} + {1'b0, add_qty};
      if (add_en && add_idx == IDX_W'(i)) begin
        cnt_d[i] = (sum > SAT) ? CNT_W'(MAX_STOCK) : sum[CNT_W-1:0];
      end else if (dec_en && dec_idx == IDX_W'(i) && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) cnt_q[i] <= CNT_W'(INIT_STOCK);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller FSM: selection, payment timeout, 4-phase dispense/cancel handshakes, service restock; outputs registered, 1-cycle response.
// Handshakes stall on the datapath: done/cancel levels are held until the peer releases its request or acknowledge.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS      = NUM_ITEMS_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned MAX_STOCK      = MAX_STOCK_DEF,
  parameter int unsigned INIT_STOCK     = INIT_STOCK_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  input  logic [3:0]       sel_index,
  input  logic             cancel_btn,
  input  logic             coin_event,
  input  logic             service_mode,
  input  logic             restock_valid,
  input  logic [3:0]       restock_index,
  input  logic [CNT_W-1:0] restock_qty,
  input  logic             reduceInventory,
  input  logic             changeState,
  input  logic             cancelledDone,
  output logic [1:0]       state,
  output logic [3:0]       curIndex,
  output logic             fullInventory,
  output logic             reduceInventoryDone,
  output logic             changeStateDone,
  output logic             cancelled,
  output logic             dispense,
  output logic             sold_out
);

  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  fsm_e             fsm_q;
  logic [3:0]       cur_idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_cur;
  logic             rid_done_q, csd_q, cxl_q, dsp_q, so_q;
  logic [CNT_W-1:0] rd_cnt, chk_cnt;
  logic             sel_ok, add_en, dec_en;

  assign sel_ok  = sel_valid && (sel_index < IDX_W'(NUM_ITEMS));
  assign add_en  = (fsm_q == S_SERVICE) && restock_valid && (restock_index < IDX_W'(NUM_ITEMS));
  assign dec_en  = (fsm_q == S_PAY) && reduceInventory;
  // A coin cycle counts as idle cycle zero, so the cancel lands TIMEOUT_CYCLES after the last coin.
  assign tmo_cur = coin_event ? '0 : tmo_q;

  vend_inventory #(
    .NUM_ITEMS (NUM_ITEMS),
    .CNT_W     (CNT_W),
    .MAX_STOCK (MAX_STOCK),
    .INIT_STOCK(INIT_STOCK)
  ) u_inv (
    .clk    (clk),
    .rst_n  (rst),
    .dec_en (dec_en),
    .dec_idx(cur_idx_q),
    .add_en (add_en),
    .add_idx(restock_index),
    .add_qty(restock_qty),
    .rd_idx (cur_idx_q),
    .rd_cnt (rd_cnt),
    .chk_idx(sel_index),
    .chk_cnt(chk_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_SELECT;
      cur_idx_q  <= '0;
      tmo_q      <= '0;
      rid_done_q <= 1'b0;
      csd_q      <= 1'b0;
      cxl_q      <= 1'b0;
      dsp_q      <= 1'b0;
      so_q       <= 1'b0;
    end else begin
      dsp_q <= 1'b0;
      so_q  <= 1'b0;
      csd_q <= (fsm_q != S_SERVICE) && changeState;
      case (fsm_q)
        S_SELECT: begin
          if (service_mode) begin
            fsm_q <= S_SERVICE;
          end else if (sel_ok) begin
            if (chk_cnt != '0) begin
              cur_idx_q <= sel_index;
              tmo_q     <= '0;
              fsm_q     <= S_PAY;
            end else begin
              so_q <= 1'b1;
            end
          end
        end
        S_PAY: begin
          if (reduceInventory) begin
            if (rd_cnt != '0) dsp_q <= 1'b1;
            else              so_q  <= 1'b1;
            rid_done_q <= 1'b1;
            fsm_q      <= S_DSP_ACK;
          end else if (cancel_btn || tmo_cur == TMO_LAST) begin
            cxl_q <= 1'b1;
            fsm_q <= S_CXL_REQ;
          end else begin
            tmo_q <= tmo_cur + TMO_W'(1);
          end
        end
        S_DSP_ACK: begin
          if (!reduceInventory) begin
            rid_done_q <= 1'b0;
            fsm_q      <= S_DSP_REL;
          end
        end
        S_DSP_REL: fsm_q <= S_SELECT;
        S_CXL_REQ: begin
          if (cancelledDone) begin
            cxl_q <= 1'b0;
            fsm_q <= S_CXL_REL;
          end
        end
        S_CXL_REL: if (!cancelledDone) fsm_q <= S_SELECT;
        S_SERVICE: if (!service_mode) fsm_q <= S_SELECT;
        default:   fsm_q <= S_SELECT;
      endcase
    end
  end

  assign state               = state_code(fsm_q);
  assign curIndex            = cur_idx_q;
  assign fullInventory       = (rd_cnt != '0);
  assign reduceInventoryDone = rid_done_q;
  assign changeStateDone     = csd_q;
  assign cancelled           = cxl_q;
  assign dispense            = dsp_q;
  assign sold_out            = so_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboarded bench for vend_sequencer: expected dispense/sold-out/cancel events queued at stimulus, popped by a monitor.
module tb_vend_sequencer;

  localparam int TMO = 20;

  logic       clk, rst;
  logic       sel_valid, cancel_btn, coin_event, service_mode, restock_valid;
  logic [3:0] sel_index, restock_index, restock_qty;
  logic       reduceInventory, changeState, cancelledDone;
  logic [1:0] state;
  logic [3:0] curIndex;
  logic       fullInventory, reduceInventoryDone, changeStateDone, cancelled, dispense, sold_out;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb_q[$];
  int         cnt_m[8];
  logic       cxl_prev;

  vend_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_index(sel_index),
    .cancel_btn(cancel_btn), .coin_event(coin_event), .service_mode(service_mode),
    .restock_valid(restock_valid), .restock_index(restock_index), .restock_qty(restock_qty),
    .reduceInventory(reduceInventory), .changeState(changeState), .cancelledDone(cancelledDone),
    .state(state), .curIndex(curIndex), .fullInventory(fullInventory),
    .reduceInventoryDone(reduceInventoryDone), .changeStateDone(changeStateDone),
    .cancelled(cancelled), .dispense(dispense), .sold_out(sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_check(input logic [7:0] ev);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected", 32'(ev), 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_event", 32'(ev), 32'(e));
    end
  endtask

  // Event codes: 1x dispense for item x, 20 sold-out, 3x cancel for item x.
  always @(negedge clk) begin
    if (!rst) begin
      cxl_prev <= 1'b0;
    end else begin
      if (dispense)               sb_check({4'd1, curIndex});
      if (sold_out)               sb_check(8'h20);
      if (cancelled && !cxl_prev) sb_check({4'd3, curIndex});
      cxl_prev <= cancelled;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int idx);
    sel_index = 4'(idx);
    sel_valid = 1'b1;
    if (idx < 8 && cnt_m[idx] == 0) sb_q.push_back(8'h20);
    tick;
    sel_valid = 1'b0;
  endtask

  task automatic buy(input int idx, input int hold);
    select(idx);
    if (idx >= 8 || cnt_m[idx] == 0) begin
      chk("sel_stay", 32'(state), 0);
      return;
    end
    chk("sel_pay", 32'(state), 1);
    chk("sel_idx", 32'(curIndex), 32'(idx));
    reduceInventory = 1'b1;
    sb_q.push_back({4'd1, 4'(idx)});
    cnt_m[idx]--;
    for (int k = 0; k < hold; k++) begin
      tick;
      chk("dsp_state", 32'(state), 2);
      chk("dsp_done_hi", 32'(reduceInventoryDone), 1);
    end
    reduceInventory = 1'b0;
    tick;
    chk("dsp_done_lo", 32'(reduceInventoryDone), 0);
    chk("dsp_rel", 32'(state), 2);
    tick;
    chk("dsp_end", 32'(state), 0);
    chk("full_inv", 32'(fullInventory), 32'(cnt_m[idx] != 0));
  endtask

  task automatic cancel_ack;
    chk("cxl_hi", 32'(cancelled), 1);
    chk("cxl_state", 32'(state), 1);
    cancelledDone = 1'b1;
    tick;
    chk("cxl_lo", 32'(cancelled), 0);
    chk("cxl_rel", 32'(state), 1);
    cancelledDone = 1'b0;
    tick;
    chk("cxl_end", 32'(state), 0);
  endtask

  // Cycle 0 is the first cycle the DUT reports PAY; a coin cycle counts as idle cycle zero.
  task automatic timeout_run(input int idx, input int coin_at, input int exp_cyc);
    int n;
    select(idx);
    chk("tmo_pay", 32'(state), 1);
    sb_q.push_back({4'd3, 4'(idx)});
    n = 0;
    while (!cancelled && n < 100) begin
      if (n == coin_at) coin_event = 1'b1;
      tick;
      coin_event = 1'b0;
      n++;
    end
    chk("tmo_cycle", 32'(n), 32'(exp_cyc));
    cancel_ack();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sel_valid = 0; sel_index = 0; cancel_btn = 0; coin_event = 0;
    service_mode = 0; restock_valid = 0; restock_index = 0; restock_qty = 0;
    reduceInventory = 0; changeState = 0; cancelledDone = 0; cxl_prev = 0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 5;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_idx", 32'(curIndex), 0);
    chk("rst_full", 32'(fullInventory), 1);
    chk("rst_outs", 32'({reduceInventoryDone, changeStateDone, cancelled, dispense, sold_out}), 0);
    tick;
    rst = 1'b1;

    changeState = 1'b1;
    tick;
    chk("cs_done_hi", 32'(changeStateDone), 1);
    changeState = 1'b0;
    tick;
    chk("cs_done_lo", 32'(changeStateDone), 0);

    buy(3, 4);

    // Reset while the dispense acknowledge is held.
    select(5);
    reduceInventory = 1'b1;
    sb_q.push_back({4'd1, 4'd5});
    tick;
    tick;
    chk("ack_state", 32'(state), 2);
    chk("ack_done", 32'(reduceInventoryDone), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_done", 32'(reduceInventoryDone), 0);
    chk("mid_rst_full", 32'(fullInventory), 1);
    reduceInventory = 1'b0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 5;
    tick;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) buy(3, 2);
    for (int i = 0; i < 6; i++) buy(2, 1);
    buy(9, 1);
    tick;

    restock_valid = 1'b1; restock_index = 4'd2; restock_qty = 4'd3;
    tick;
    restock_valid = 1'b0;
    buy(2, 1);

    timeout_run(1, -1, TMO);
    timeout_run(1, 15, 35);

    select(6);
    cancel_btn = 1'b1;
    sb_q.push_back({4'd3, 4'd6});
    tick;
    cancel_btn = 1'b0;
    cancel_ack();

    select(4);
    cancel_btn = 1'b1;
    reduceInventory = 1'b1;
    sb_q.push_back({4'd1, 4'd4});
    cnt_m[4]--;
    tick;
    cancel_btn = 1'b0;
    chk("race_cxl", 32'(cancelled), 0);
    chk("race_state", 32'(state), 2);
    reduceInventory = 1'b0;
    tick;
    tick;
    chk("race_end", 32'(state), 0);
    chk("race_cxl_end", 32'(cancelled), 0);

    // Service key raised during PAY takes effect only once back in SELECT.
    select(7);
    service_mode = 1'b1;
    tick;
    chk("svc_defer", 32'(state), 1);
    cancel_btn = 1'b1;
    sb_q.push_back({4'd3, 4'd7});
    tick;
    cancel_btn = 1'b0;
    cancel_ack();
    tick;
    chk("svc_enter", 32'(state), 3);

    changeState = 1'b1;
    tick;
    chk("svc_cs_stall", 32'(changeStateDone), 0);
    restock_valid = 1'b1;
    restock_index = 4'd0; restock_qty = 4'd15;
    tick;
    restock_index = 4'd2; restock_qty = 4'd2;
    tick;
    restock_index = 4'd9; restock_qty = 4'd3;
    tick;
    restock_valid = 1'b0;
    cnt_m[0] = (cnt_m[0] + 15 > 15) ? 15 : cnt_m[0] + 15;
    cnt_m[2] = cnt_m[2] + 2;
    chk("svc_cs_stall2", 32'(changeStateDone), 0);
    service_mode = 1'b0;
    tick;
    chk("svc_exit", 32'(state), 0);
    chk("svc_cs_exit", 32'(changeStateDone), 0);
    tick;
    chk("svc_cs_done", 32'(changeStateDone), 1);
    changeState = 1'b0;
    tick;
    chk("svc_cs_lo", 32'(changeStateDone), 0);

    for (int i = 0; i < 16; i++) buy(0, 1);
    for (int i = 0; i < 3; i++) buy(2, 1);

    repeat (3) tick;
    chk("sb_left", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
